// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl
// FIFO controller wrapped around a single-port 16x8 SRAM macro whose read
// data appears one cycle after the read is issued. It presents a
// valid/ready stream on both sides and keeps one extra word in a registered
// output stage, so total capacity is WORD_DEPTH + 1 words.
//
// The SRAM port is shared: a read (prefetch into the output register) wins
// over a write in any given cycle. Reads need the output stage to be free
// (or being popped) and no read already in flight, so they can issue at
// most every other cycle and the producer is never starved.
module sram_fifo_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int WORD_DEPTH = 16,
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_data,

  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_data,

  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,

  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [WORD_WIDTH-1:0] sram_din,
  output logic                  sram_we,
  input  logic [WORD_WIDTH-1:0] sram_dout
);

  localparam logic [ADDR_WIDTH-1:0] PTR_LAST   = ADDR_WIDTH'(WORD_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] PTR_STEP   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_STEP = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(WORD_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_inflight;

  logic                  pop;
  logic                  rd_issue;
  logic                  wr_go;

  // Occupancy flags refer to the SRAM only; the output register is separate.
  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);

  // A read is issued when there is data in SRAM, no read is pending, and the
  // output register will be free at the next edge. Writes take what is left.
  assign pop      = out_valid & out_ready;
  assign rd_issue = ~empty & ~rd_inflight & (~out_valid | pop);
  assign in_ready = rst_n & ~full & ~rd_issue;
  assign wr_go    = in_valid & in_ready;

  // Drive the SRAM pins; idle cycles park on a harmless read of rd_ptr.
  always_comb begin
    sram_we   = 1'b1;
    sram_addr = rd_ptr;
    sram_din  = '0;
    if (wr_go) begin
      sram_we   = 1'b0;
      sram_addr = wr_ptr;
      sram_din  = in_data;
    end
  end

  // Advance the write and read pointers, wrapping at the last SRAM entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_go) begin
        if (wr_ptr == PTR_LAST) begin
          wr_ptr <= '0;
        end else begin
          wr_ptr <= wr_ptr + PTR_STEP;
        end
      end
      if (rd_issue) begin
        if (rd_ptr == PTR_LAST) begin
          rd_ptr <= '0;
        end else begin
          rd_ptr <= rd_ptr + PTR_STEP;
        end
      end
    end
  end

  // Track SRAM occupancy; read and write are exclusive so it moves by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (rd_issue) begin
      count <= count - COUNT_STEP;
    end else if (wr_go) begin
      count <= count + COUNT_STEP;
    end
  end

  // Capture SRAM read data one cycle after issue; a pop alone empties the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      rd_inflight <= rd_issue;
      if (rd_inflight) begin
        out_valid <= 1'b1;
        out_data  <= sram_dout;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl
// Directed bench for sram_fifo_ctrl with a behavioural 16x8 single-port SRAM
// (registered read data) and a FIFO scoreboard of accepted words.
module tb_sram_fifo_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic [3:0] sram_addr;
  logic [7:0] sram_din;
  logic       sram_we;
  logic [7:0] sram_dout;

  logic [7:0] mem [16];
  logic [7:0] scoreQ [$];
  logic [3:0] wrModel;
  int         vectorCount;
  int         missCount;
  int         popCount;

  sram_fifo_ctrl #(
    .ADDR_WIDTH(4),
    .WORD_DEPTH(16),
    .WORD_WIDTH(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .sram_addr (sram_addr),
    .sram_din  (sram_din),
    .sram_we   (sram_we),
    .sram_dout (sram_dout)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port SRAM model: write when we=0, registered read otherwise.
  always @(posedge clk) begin
    if (!sram_we) begin
      mem[sram_addr] <= sram_din;
    end else begin
      sram_dout <= mem[sram_addr];
    end
  end

  // Hard stop in case a loop bound is ever missed.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive inputs just after a falling edge and let combinational outputs settle.
  task automatic applyStimulus(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
  endtask

  // Record this cycle's handshakes against the scoreboard, then advance a cycle.
  task automatic clockCycle();
    logic [7:0] expWord;
    if (in_valid && in_ready) begin
      checkOutput("write we", 32'(sram_we), 32'd0);
      checkOutput("write addr", 32'(sram_addr), 32'(wrModel));
      checkOutput("write din", 32'(sram_din), 32'(in_data));
      scoreQ.push_back(in_data);
      wrModel = wrModel + 4'd1;
    end
    if (out_valid && out_ready) begin
      popCount++;
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected pop", 32'(out_data), 32'hFFFF_FFFF);
      end else begin
        expWord = scoreQ.pop_front();
        checkOutput("pop order", 32'(out_data), 32'(expWord));
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int k;
    int cyc;
    int stallCyc;
    int sent;
    int wraps;
    int popSnap;

    vectorCount = 0;
    missCount   = 0;
    popCount    = 0;
    wrModel     = 4'd0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = 8'h00;
    out_ready   = 1'b0;
    sram_dout   = 8'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'hEE;

    // 1: reset state, then release
    @(negedge clk);
    applyStimulus(1'b1, 8'h99, 1'b0);
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst out_data", 32'(out_data), 32'h00);
    checkOutput("rst count", 32'(count), 32'd0);
    checkOutput("rst empty", 32'(empty), 32'd1);
    checkOutput("rst full", 32'(full), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    checkOutput("release sram_we", 32'(sram_we), 32'd1);

    // 2: fill with out_ready low; one prefetch stall after the first write
    $display("[TB] fill 17 words");
    k = 0;
    cyc = 0;
    stallCyc = -1;
    while (k < 17 && cyc < 60) begin
      applyStimulus(1'b1, 8'(k), 1'b0);
      if (in_ready) k++;
      else if (stallCyc < 0) stallCyc = cyc;
      clockCycle();
      cyc++;
    end
    checkOutput("fill accepted", 32'(k), 32'd17);
    checkOutput("prefetch stall cycle", 32'(stallCyc), 32'd1);
    applyStimulus(1'b1, 8'h11, 1'b0);
    checkOutput("full out_valid", 32'(out_valid), 32'd1);
    checkOutput("full out_data", 32'(out_data), 32'h00);
    checkOutput("full count", 32'(count), 32'd16);
    checkOutput("full flag", 32'(full), 32'd1);
    checkOutput("full in_ready", 32'(in_ready), 32'd0);
    checkOutput("full sram_we", 32'(sram_we), 32'd1);
    clockCycle();
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ignored push count", 32'(count), 32'd16);
    checkOutput("ignored push idle addr", 32'(sram_addr), 32'd1);

    // 3: drain everything in order
    $display("[TB] drain");
    cyc = 0;
    popSnap = popCount;
    while (scoreQ.size() > 0 && cyc < 100) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockCycle();
      cyc++;
    end
    checkOutput("drain left", 32'(scoreQ.size()), 32'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockCycle();
    end
    checkOutput("drain pops", 32'(popCount - popSnap), 32'd17);
    checkOutput("drain count", 32'(count), 32'd0);
    checkOutput("drain empty", 32'(empty), 32'd1);
    checkOutput("drain out_valid", 32'(out_valid), 32'd0);

    // 4: streaming 40 words with both sides always willing
    $display("[TB] streaming");
    sent = 0;
    wraps = 0;
    cyc = 0;
    while ((sent < 40 || scoreQ.size() > 0) && cyc < 400) begin
      applyStimulus(sent < 40, 8'(8'hA0 + sent), 1'b1);
      if (in_valid && in_ready) begin
        if (sram_addr == 4'd15) wraps++;
        sent++;
      end
      if (count > 5'd16) checkOutput("count bound", 32'(count), 32'd16);
      clockCycle();
      cyc++;
    end
    checkOutput("stream sent", 32'(sent), 32'd40);
    checkOutput("stream left", 32'(scoreQ.size()), 32'd0);
    checkOutput("stream wr wraps", 32'(wraps), 32'd2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockCycle();
    end
    checkOutput("stream end empty", 32'(empty), 32'd1);

    // 5: write blocked in the exact cycle a read issues
    $display("[TB] read/write conflict");
    applyStimulus(1'b1, 8'h66, 1'b0);
    checkOutput("conflict pre in_ready", 32'(in_ready), 32'd1);
    clockCycle();
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("conflict in_ready", 32'(in_ready), 32'd0);
    checkOutput("conflict sram_we", 32'(sram_we), 32'd1);
    checkOutput("conflict sram_addr", 32'(sram_addr), 32'd9);
    clockCycle();
    applyStimulus(1'b1, 8'h77, 1'b0);
    checkOutput("retry in_ready", 32'(in_ready), 32'd1);
    checkOutput("retry sram_we", 32'(sram_we), 32'd0);
    checkOutput("retry sram_addr", 32'(sram_addr), 32'd10);
    checkOutput("retry sram_din", 32'(sram_din), 32'h77);
    clockCycle();
    cyc = 0;
    while (scoreQ.size() > 0 && cyc < 20) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockCycle();
      cyc++;
    end
    checkOutput("conflict drain left", 32'(scoreQ.size()), 32'd0);

    // 6: reset the cycle after a read issue
    $display("[TB] reset mid-stream");
    k = 0;
    cyc = 0;
    while (k < 3 && cyc < 20) begin
      applyStimulus(1'b1, 8'(8'h30 + k), 1'b0);
      if (in_ready) k++;
      clockCycle();
      cyc++;
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre-reset out_valid", 32'(out_valid), 32'd1);
    clockCycle();
    rst_n = 1'b0;
    #1;
    checkOutput("midrst out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst count", 32'(count), 32'd0);
    checkOutput("midrst in_ready", 32'(in_ready), 32'd0);
    scoreQ.delete();
    wrModel = 4'd0;
    applyStimulus(1'b0, 8'h00, 1'b0);
    clockCycle();
    clockCycle();
    rst_n = 1'b1;
    #1;
    popSnap = popCount;
    sent = 0;
    cyc = 0;
    while ((sent < 2 || scoreQ.size() > 0) && cyc < 40) begin
      applyStimulus(sent < 2, 8'(8'h5A + sent), 1'b1);
      if (in_valid && in_ready) sent++;
      clockCycle();
      cyc++;
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      clockCycle();
    end
    checkOutput("post-reset pops", 32'(popCount - popSnap), 32'd2);
    checkOutput("post-reset last data", 32'(out_data), 32'h5B);
    checkOutput("post-reset empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Single-clock FIFO controller that owns the single-port 16x8 SRAM macro and drives its addr/din/we pins. It turns the raw SRAM into a valid/ready stream buffer for the producer and consumer stages around the memory. It handles port arbitration, pointer wrap, occupancy tracking and capture of the 1-cycle registered SRAM read data. Total capacity is WORD_DEPTH entries in SRAM plus one entry in the output register.

Parameters:
ADDR_WIDTH, 4, SRAM address width
WORD_DEPTH, 16, SRAM entries (= 2**ADDR_WIDTH)
WORD_WIDTH, 8, data width

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has a word
in_ready  out  1  controller accepts the word this cycle
in_data  in  WORD_WIDTH  write word
out_valid  out  1  out_data holds a valid word
out_ready  in  1  consumer takes the word this cycle
out_data  out  WORD_WIDTH  read word (registered)
count  out  ADDR_WIDTH+1  SRAM occupancy, 0..WORD_DEPTH
full  out  1  count == WORD_DEPTH
empty  out  1  count == 0
sram_addr  out  ADDR_WIDTH  to SRAM addr
sram_din  out  WORD_WIDTH  to SRAM din
sram_we  out  1  to SRAM we: 0 = write, 1 = read
sram_dout  in  WORD_WIDTH  from SRAM dout; valid the cycle after a read issue

Behaviour:
- Reset (rst_n low, async): wr_ptr=0, rd_ptr=0, count=0, rd_inflight=0, out_valid=0, out_data=0. in_ready forced 0 while rst_n is low. SRAM contents are not cleared.
- pop = out_valid & out_ready.
- rd_issue = !empty & !rd_inflight & (!out_valid | pop). Combinational. Read has priority over write.
- wr_go = in_valid & in_ready, where in_ready = !full & !rd_issue.
- SRAM drive (combinational):
  - rd_issue: sram_we=1, sram_addr=rd_ptr.
  - wr_go: sram_we=0, sram_addr=wr_ptr, sram_din=in_data.
  - Idle: sram_we=1, sram_addr=rd_ptr, sram_din=0. Idle reads are harmless and never captured.
- Never write and read in the same cycle (single port).
- On rd_issue: rd_ptr+1 with mod WORD_DEPTH wrap, count-1, rd_inflight<=1.
- On wr_go: wr_ptr+1 with wrap, count+1.
- count changes by at most ±1 per cycle.
- Cycle after rd_issue (rd_inflight=1): at that posedge, out_data<=sram_dout, out_valid<=1, rd_inflight<=0.
- Read latency: issue in cycle N, out_valid high in cycle N+2.
- pop without a concurrent capture: out_valid<=0. out_data holds its last value.
- out_valid and out_data are stable while out_valid & !out_ready.
- Write throughput: 1 word/cycle when no read is issued. Reads issue at most every 2 cycles, so writes are never starved.
- Full: in_ready=0. in_valid is ignored and no pointer moves.
- Empty: no read issued. out_valid drops after the last pop.
- Reset mid-operation: any in-flight read is discarded and all state returns to reset values.

Test Plan:
1. Hold rst_n=0 -> out_valid=0, out_data=0x00, count=0, empty=1, full=0, in_ready=0. Release -> in_ready=1, sram_we=1.
2. out_ready=0, push 17 words 0x00..0x10 -> one prefetch read occurs after the first write (in_ready=0 for that cycle). End state: out_valid=1, out_data=0x00, count=16, full=1, in_ready=0. An 18th in_valid is ignored.
3. From scenario 2, out_ready=1 -> out_data sequence 0x00..0x10 in order, no duplicates. Ends with count=0, empty=1, out_valid=0.
4. Streaming: in_valid=1 and out_ready=1 continuously for 40 words 0xA0.. -> output order matches input. wr_ptr/rd_ptr wrap 15->0 at least twice. count never exceeds 16.
5. Conflict: in_valid=1 in the exact cycle rd_issue fires -> in_ready=0, sram_we=1, sram_addr=rd_ptr. The word is accepted next cycle with sram_we=0 and data unchanged.
6. Pull rst_n low the cycle after a read issue, mid-stream -> out_valid=0, count=0 immediately. After release, push 0x5A, 0x5B -> output is exactly 0x5A then 0x5B.
